parallel_port_capture: RTL

PARALLEL_PORT_CAPTURE -- requirements
Module: parallel_port_capture

---
 rtl/parallel_port_capture_if.sv | 18 +
 rtl/parallel_port_capture.sv | 113 +++++++++++
 2 files changed

// File: rtl/parallel_port_capture_if.sv
// Avalon-MM slave bus bundle for the parallel port capture block.
interface parallel_port_capture_if;
    logic [2:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;

    modport master (
        output avs_address, avs_read, avs_write, avs_writedata,
        input  avs_readdata
    );

    modport slave (
        input  avs_address, avs_read, avs_write, avs_writedata,
        output avs_readdata
    );
endinterface

// File: rtl/parallel_port_capture.sv
// Bidirectional GPIO with synchronized pin capture, sticky rising-edge flags,
// masked level interrupt and a rising-edge counter on pin 0.
module parallel_port_capture #(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    parallel_port_capture_if.slave  avs,
    output logic                    irq,
    inout  wire  [WIDTH-1:0]        pio
);
    localparam logic [2:0] ADDR_DIR   = 3'd0;
    localparam logic [2:0] ADDR_PIN   = 3'd1;
    localparam logic [2:0] ADDR_PORT  = 3'd2;
    localparam logic [2:0] ADDR_SET   = 3'd3;
    localparam logic [2:0] ADDR_CLR   = 3'd4;
    localparam logic [2:0] ADDR_EDGE  = 3'd5;
    localparam logic [2:0] ADDR_MASK  = 3'd6;
    localparam logic [2:0] ADDR_COUNT = 3'd7;

    logic [WIDTH-1:0] dir_q, port_q, edge_q, mask_q;
    logic [31:0]      count_q;
    logic [31:0]      rdata_q;
    logic [31:0]      rd_mux;

    logic [WIDTH-1:0] sync_p [SYNC_STAGES];
    logic [WIDTH-1:0] pin;
    logic [WIDTH-1:0] pin_dly;
    logic [SYNC_STAGES:0] vld_p;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] wd;

    logic wr_dir, wr_port, wr_set, wr_clr, wr_edge, wr_mask, wr_count;

    function automatic logic [31:0] ext(input logic [WIDTH-1:0] v);
        logic [31:0] r;
        r = '0;
        r[WIDTH-1:0] = v;
        return r;
    endfunction

    for (genvar i = 0; i < WIDTH; i++) begin : g_pio
        assign pio[i] = dir_q[i] ? port_q[i] : 1'bz;
    end

    assign wd       = avs.avs_writedata[WIDTH-1:0];
    assign wr_dir   = avs.avs_write && (avs.avs_address == ADDR_DIR);
    assign wr_port  = avs.avs_write && (avs.avs_address == ADDR_PORT);
    assign wr_set   = avs.avs_write && (avs.avs_address == ADDR_SET);
    assign wr_clr   = avs.avs_write && (avs.avs_address == ADDR_CLR);
    assign wr_edge  = avs.avs_write && (avs.avs_address == ADDR_EDGE);
    assign wr_mask  = avs.avs_write && (avs.avs_address == ADDR_MASK);
    assign wr_count = avs.avs_write && (avs.avs_address == ADDR_COUNT);

    // Synchronizer chain; vld_p tracks when pin_dly holds a real sample so a
    // pin already high at reset release is not mistaken for a rising edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_p[i] <= '0;
            pin_dly <= '0;
            vld_p   <= '0;
        end else begin
            sync_p[0] <= pio;
            for (int i = 1; i < SYNC_STAGES; i++) sync_p[i] <= sync_p[i-1];
            pin_dly <= pin;
            vld_p   <= {vld_p[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign pin  = sync_p[SYNC_STAGES-1];
    assign rise = vld_p[SYNC_STAGES] ? (pin & ~pin_dly) : '0;

    always_comb begin
        rd_mux = '0;
        case (avs.avs_address)
            ADDR_DIR:   rd_mux = ext(dir_q);
            ADDR_PIN:   rd_mux = ext(pin);
            ADDR_PORT:  rd_mux = ext(port_q);
            ADDR_EDGE:  rd_mux = ext(edge_q);
            ADDR_MASK:  rd_mux = ext(mask_q);
            ADDR_COUNT: rd_mux = count_q;
            default:    rd_mux = '0;
        endcase
    end

    // Register file, edge flags, counter, interrupt and read response
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dir_q   <= '0;
            port_q  <= '0;
            edge_q  <= '0;
            mask_q  <= '0;
            count_q <= '0;
            rdata_q <= '0;
            irq     <= 1'b0;
        end else begin
            if (wr_dir) dir_q <= wd;
            if (wr_port)     port_q <= wd;
            else if (wr_set) port_q <= port_q | wd;
            else if (wr_clr) port_q <= port_q & ~wd;
            // A new edge wins over a simultaneous software clear.
            edge_q <= (wr_edge ? (edge_q & ~wd) : edge_q) | rise;
            if (wr_mask) mask_q <= wd;
            if (wr_count)     count_q <= avs.avs_writedata;
            else if (rise[0]) count_q <= count_q + 32'd1;
            irq <= |(edge_q & mask_q);
            if (avs.avs_read) rdata_q <= rd_mux;
        end
    end

    assign avs.avs_readdata = rdata_q;
endmodule
